// File: rtl/risc_spm_control_unit_pkg.sv
// Shared definitions for the RISC-SPM instruction sequencer: opcodes, bus
// select codes, FSM state encoding and the bundled control-strobe struct.
package risc_spm_control_unit_pkg;

  localparam int STATE_W = 4;

  // Opcode field, instruction[ws-1:ws-4]
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;

  localparam logic [2:0] SEL1_R0 = 3'd0;
  localparam logic [2:0] SEL1_R1 = 3'd1;
  localparam logic [2:0] SEL1_R2 = 3'd2;
  localparam logic [2:0] SEL1_R3 = 3'd3;
  localparam logic [2:0] SEL1_PC = 3'd4;

  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EX1  = 4'd4,
    S_RD1  = 4'd5,
    S_RD2  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_BR1  = 4'd9,
    S_BR2  = 4'd10,
    S_HALT = 4'd11
  } state_t;

  typedef struct packed {
    logic [3:0] load_r;
    logic       load_pc;
    logic       inc_pc;
    logic [2:0] sel_bus_1;
    logic [1:0] sel_bus_2;
    logic       load_ir;
    logic       load_add_r;
    logic       load_reg_y;
    logic       load_reg_z;
    logic       write;
    logic       halted;
  } ctrl_t;

  // Register-field to Bus_1 select code (R0..R3 map directly).
  function automatic logic [2:0] reg_sel(input logic [1:0] r);
    return {1'b0, r};
  endfunction

  // Register-field to one-hot Load_Rn vector.
  function automatic logic [3:0] reg_load(input logic [1:0] r);
    return 4'b0001 << r;
  endfunction

endpackage

// File: rtl/risc_spm_control_unit.sv
// Instruction-sequencing FSM of RISC-SPM: fetch, decode and execute strobes
// for the register file, buses, PC, IR, address register and memory.
module risc_spm_control_unit
  import risc_spm_control_unit_pkg::*;
#(
  parameter int ws = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [ws-1:0] instruction,
  input  logic          zero,
  output logic          Load_R0,
  output logic          Load_R1,
  output logic          Load_R2,
  output logic          Load_R3,
  output logic          Load_PC,
  output logic          Inc_PC,
  output logic [2:0]    Sel_Bus_1_Mux,
  output logic [1:0]    Sel_Bus_2_Mux,
  output logic          Load_IR,
  output logic          Load_Add_R,
  output logic          Load_Reg_Y,
  output logic          Load_Reg_Z,
  output logic          write,
  output logic          halted,
  output logic [3:0]    dbg_state
);

  state_t     state_q;
  state_t     state_d;
  ctrl_t      ctrl;
  logic [3:0] opcode;
  logic [1:0] src;
  logic [1:0] dest;

  assign opcode = instruction[ws-1:ws-4];
  assign src    = instruction[3:2];
  assign dest   = instruction[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Outputs are decoded from the current state so that an asynchronous
  // reset forces every strobe low within the same cycle.
  always_comb begin
    ctrl    = '0;
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: state_d = S_FET1;
      S_FET1: begin
        ctrl.sel_bus_1  = SEL1_PC;
        ctrl.sel_bus_2  = SEL2_BUS1;
        ctrl.load_add_r = 1'b1;
        state_d         = S_FET2;
      end
      S_FET2: begin
        ctrl.sel_bus_2 = SEL2_MEM;
        ctrl.load_ir   = 1'b1;
        ctrl.inc_pc    = 1'b1;
        state_d        = S_DEC;
      end
      S_DEC: begin
        case (opcode)
          OP_NOP: state_d = S_FET1;
          OP_ADD, OP_SUB, OP_AND: begin
            ctrl.sel_bus_1  = reg_sel(src);
            ctrl.sel_bus_2  = SEL2_BUS1;
            ctrl.load_reg_y = 1'b1;
            state_d         = S_EX1;
          end
          OP_NOT: begin
            ctrl.sel_bus_1  = reg_sel(src);
            ctrl.sel_bus_2  = SEL2_ALU;
            ctrl.load_reg_z = 1'b1;
            ctrl.load_r     = reg_load(dest);
            state_d         = S_FET1;
          end
          OP_RD, OP_WR, OP_BR: begin
            ctrl.sel_bus_1  = SEL1_PC;
            ctrl.sel_bus_2  = SEL2_BUS1;
            ctrl.load_add_r = 1'b1;
            if (opcode == OP_RD)      state_d = S_RD1;
            else if (opcode == OP_WR) state_d = S_WR1;
            else                      state_d = S_BR1;
          end
          OP_BRZ: begin
            if (zero) begin
              ctrl.sel_bus_1  = SEL1_PC;
              ctrl.sel_bus_2  = SEL2_BUS1;
              ctrl.load_add_r = 1'b1;
              state_d         = S_BR1;
            end else begin
              // Branch not taken: step over the target-address byte.
              ctrl.inc_pc = 1'b1;
              state_d     = S_FET1;
            end
          end
          default: state_d = S_HALT;
        endcase
      end
      S_EX1: begin
        ctrl.sel_bus_1  = reg_sel(dest);
        ctrl.sel_bus_2  = SEL2_ALU;
        ctrl.load_reg_z = 1'b1;
        ctrl.load_r     = reg_load(dest);
        state_d         = S_FET1;
      end
      S_RD1: begin
        ctrl.sel_bus_2  = SEL2_MEM;
        ctrl.load_add_r = 1'b1;
        ctrl.inc_pc     = 1'b1;
        state_d         = S_RD2;
      end
      S_RD2: begin
        ctrl.sel_bus_2 = SEL2_MEM;
        ctrl.load_r    = reg_load(dest);
        state_d        = S_FET1;
      end
      S_WR1: begin
        ctrl.sel_bus_2  = SEL2_MEM;
        ctrl.load_add_r = 1'b1;
        ctrl.inc_pc     = 1'b1;
        state_d         = S_WR2;
      end
      S_WR2: begin
        ctrl.sel_bus_1 = reg_sel(src);
        ctrl.write     = 1'b1;
        state_d        = S_FET1;
      end
      S_BR1: begin
        ctrl.sel_bus_2  = SEL2_MEM;
        ctrl.load_add_r = 1'b1;
        state_d         = S_BR2;
      end
      S_BR2: begin
        ctrl.sel_bus_2 = SEL2_MEM;
        ctrl.load_pc   = 1'b1;
        state_d        = S_FET1;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
        state_d     = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Load_R0       = ctrl.load_r[0];
  assign Load_R1       = ctrl.load_r[1];
  assign Load_R2       = ctrl.load_r[2];
  assign Load_R3       = ctrl.load_r[3];
  assign Load_PC       = ctrl.load_pc;
  assign Inc_PC        = ctrl.inc_pc;
  assign Sel_Bus_1_Mux = ctrl.sel_bus_1;
  assign Sel_Bus_2_Mux = ctrl.sel_bus_2;
  assign Load_IR       = ctrl.load_ir;
  assign Load_Add_R    = ctrl.load_add_r;
  assign Load_Reg_Y    = ctrl.load_reg_y;
  assign Load_Reg_Z    = ctrl.load_reg_z;
  assign write         = ctrl.write;
  assign halted        = ctrl.halted;
  assign dbg_state     = state_q;

endmodule
